// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: default widths, mode encodings and the
// slave_port state type.
package bus_pkg;

    localparam int BUS_ADDR_WIDTH       = 16;
    localparam int SLAVE_MEM_ADDR_WIDTH = 12;
    localparam int BUS_DATA_WIDTH       = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_MEM_WR  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RDATA   = 3'd6
    } slave_port_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_port_serial_shifter.sv
// serial_shifter: LSB-first shift register with a parallel load.
// Load takes priority over shift; shift_next exposes the post-shift word.
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic [WIDTH-1:0] shift_next
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    generate
        if (WIDTH == 1) begin : g_single
            assign shift_next = serial_in;
        end else begin : g_multi
            assign shift_next = {serial_in, data_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = shift_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign serial_out = data_q[0];

endmodule

// File: rtl/slave_port.sv
// slave_port: serial-bus slave front end driving a single-cycle synchronous memory.
// Optional mid-frame stall abort is enabled by defining SLAVE_PORT_TIMEOUT_EN.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = SLAVE_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  timeout_err
);

    localparam int IN_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(IN_W + 1);
    // Address bit 0 is taken in IDLE, so ADDR itself only counts ADDR_WIDTH-1 bits.
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'((ADDR_WIDTH > 1) ? ADDR_WIDTH - 2 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    slave_port_state_t state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  sready_q, sready_d;
    logic                  svalid_q, svalid_d;
    logic                  mem_wen_q, mem_wen_d;
    logic                  mem_ren_q, mem_ren_d;

    logic                  in_shift_en;
    logic                  out_load_en;
    logic                  out_shift_en;
    logic                  abort;
    logic [IN_W-1:0]       in_next;
    logic                  in_sout_unused;
    logic [DATA_WIDTH-1:0] out_next_unused;

    serial_shifter #(.WIDTH(IN_W)) u_in_shift (
        .clk        (clk),
        .rstn       (rstn),
        .shift_en   (in_shift_en),
        .serial_in  (swdata),
        .load_en    (1'b0),
        .load_data  ({IN_W{1'b0}}),
        .serial_out (in_sout_unused),
        .shift_next (in_next)
    );

    serial_shifter #(.WIDTH(DATA_WIDTH)) u_out_shift (
        .clk        (clk),
        .rstn       (rstn),
        .shift_en   (out_shift_en),
        .serial_in  (1'b0),
        .load_en    (out_load_en),
        .load_data  (mem_rdata),
        .serial_out (srdata),
        .shift_next (out_next_unused)
    );

`ifdef SLAVE_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q;

    always_comb begin
        to_cnt_d = '0;
        abort    = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_WDATA) && !mvalid) begin
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                abort = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= abort;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign abort          = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        in_shift_en  = 1'b0;
        out_load_en  = 1'b0;
        out_shift_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_d      = smode;
                    in_shift_en = 1'b1;
                    if (ADDR_WIDTH == 1) begin
                        mem_addr_d = in_next[IN_W-1 -: ADDR_WIDTH];
                        state_d    = (smode == MODE_WRITE) ? ST_WDATA : ST_RD_REQ;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (mvalid) begin
                    in_shift_en = 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        mem_addr_d = in_next[IN_W-1 -: ADDR_WIDTH];
                        state_d    = (mode_q == MODE_WRITE) ? ST_WDATA : ST_RD_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (mvalid) begin
                    in_shift_en = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        mem_wdata_d = in_next[IN_W-1 -: DATA_WIDTH];
                        state_d     = ST_MEM_WR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_MEM_WR:  state_d = ST_IDLE;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                out_load_en = 1'b1;
                state_d     = ST_RDATA;
            end
            ST_RDATA: begin
                out_shift_en = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        sready_d  = (state_d == ST_IDLE);
        svalid_d  = (state_d == ST_RDATA);
        mem_wen_d = (state_d == ST_MEM_WR);
        mem_ren_d = (state_d == ST_RD_REQ);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sready_q    <= 1'b1;
            svalid_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sready_q    <= sready_d;
            svalid_q    <= svalid_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sready    = sready_q;
    assign svalid    = svalid_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a one-cycle-latency memory model.
// The stall scenario checks abort behaviour when SLAVE_PORT_TIMEOUT_EN is defined.
module tb_slave_port;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        swdata = 1'b0;
    logic        smode = 1'b0;
    logic        mvalid = 1'b0;
    logic        srdata;
    logic        svalid;
    logic        sready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata = 8'h00;
    logic        timeout_err;

    int tests_run = 0;
    int tests_failed = 0;
    int wen_count = 0;
    int ren_count = 0;
    int cycle_cnt = 0;
    logic [7:0] mem [0:4095];

    slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .swdata      (swdata),
        .smode       (smode),
        .mvalid      (mvalid),
        .srdata      (srdata),
        .svalid      (svalid),
        .sready      (sready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on mem_wen, read data one cycle after mem_ren.
    always @(posedge clk) begin
        cycle_cnt = cycle_cnt + 1;
        if (mem_wen === 1'b1) begin
            wen_count = wen_count + 1;
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_ren === 1'b1) begin
            ren_count = ren_count + 1;
            mem_rdata <= mem[mem_addr];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycles=%0d required<50000", cycle_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic m);
        swdata = b;
        smode  = m;
        mvalid = 1'b1;
        step();
        mvalid = 1'b0;
        swdata = 1'b0;
    endtask

    task automatic send_frame(input logic m, input logic [11:0] a, input logic [7:0] d);
        for (int i = 0; i < 12; i++) send_bit(a[i], m);
        if (m) for (int i = 0; i < 8; i++) send_bit(d[i], m);
    endtask

    task automatic collect_read(output logic early, output logic [7:0] data, output int nvalid);
        step();
        early  = svalid;
        step();
        data   = 8'h00;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (svalid === 1'b1) nvalid++;
            data[i] = srdata;
            step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        tests_run++; if (sready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_sready: got %b want 1", sready); end
        tests_run++; if ({svalid, srdata, mem_wen, mem_ren, timeout_err} !== 5'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes: got %b want 00000", {svalid, srdata, mem_wen, mem_ren, timeout_err}); end
        tests_run++; if ({mem_addr, mem_wdata} !== 20'h0) begin tests_failed++; $display("[TB] FAIL reset_buses: got %h want 00000", {mem_addr, mem_wdata}); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_write();
        int w0;
        w0 = wen_count;
        send_bit(1'b1, 1'b1);
        tests_run++; if (sready !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_sready_fall: got %b want 0", sready); end
        for (int i = 1; i < 12; i++) send_bit(((12'h0A5 >> i) & 12'h1) != 0, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h1) != 0, 1'b1);
        tests_run++; if (mem_wen !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_wen: got %b want 1", mem_wen); end
        tests_run++; if (mem_addr !== 12'h0A5) begin tests_failed++; $display("[TB] FAIL write_addr: got %h want 0a5", mem_addr); end
        tests_run++; if (mem_wdata !== 8'h3C) begin tests_failed++; $display("[TB] FAIL write_data: got %h want 3c", mem_wdata); end
        step();
        tests_run++; if ({mem_wen, sready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL write_end: got wen,sready=%b want 01", {mem_wen, sready}); end
        repeat (3) step();
        tests_run++; if (wen_count - w0 !== 1) begin tests_failed++; $display("[TB] FAIL write_wen_count: got %0d want 1", wen_count - w0); end
    endtask

    task automatic test_read();
        logic early;
        logic [7:0] data;
        int nvalid;
        int r0;
        r0 = ren_count;
        send_frame(1'b0, 12'h0A5, 8'h00);
        tests_run++; if ({mem_ren, mem_wen} !== 2'b10) begin tests_failed++; $display("[TB] FAIL read_ren: got ren,wen=%b want 10", {mem_ren, mem_wen}); end
        tests_run++; if (mem_addr !== 12'h0A5) begin tests_failed++; $display("[TB] FAIL read_addr: got %h want 0a5", mem_addr); end
        collect_read(early, data, nvalid);
        tests_run++; if (early !== 1'b0) begin tests_failed++; $display("[TB] FAIL read_early_valid: got %b want 0", early); end
        tests_run++; if (data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL read_data: got %h want 3c", data); end
        tests_run++; if (nvalid !== 8) begin tests_failed++; $display("[TB] FAIL read_valid_len: got %0d want 8", nvalid); end
        tests_run++; if ({svalid, sready} !== 2'b01) begin tests_failed++; $display("[TB] FAIL read_end: got svalid,sready=%b want 01", {svalid, sready}); end
        tests_run++; if (ren_count - r0 !== 1) begin tests_failed++; $display("[TB] FAIL read_ren_count: got %0d want 1", ren_count - r0); end
    endtask

    task automatic test_gap_write();
        int w0;
        w0 = wen_count;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1, (i == 0) ? 1'b1 : 1'b0);
            if (i == 3) repeat (5) begin swdata = ~swdata; step(); end
        end
        tests_run++; if (sready !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_sready: got %b want 0", sready); end
        for (int i = 0; i < 8; i++) begin
            send_bit(((8'h81 >> i) & 8'h1) != 0, 1'b0);
            if (i == 6) repeat (3) begin swdata = ~swdata; step(); end
        end
        tests_run++; if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 8'h81}) begin tests_failed++; $display("[TB] FAIL gap_write: got wen,addr,data=%b,%h,%h want 1,fff,81", mem_wen, mem_addr, mem_wdata); end
        repeat (4) step();
        tests_run++; if (wen_count - w0 !== 1) begin tests_failed++; $display("[TB] FAIL gap_wen_count: got %0d want 1", wen_count - w0); end
        tests_run++; if (mem[12'hFFF] !== 8'h81) begin tests_failed++; $display("[TB] FAIL gap_mem: got %h want 81", mem[12'hFFF]); end
    endtask

    task automatic test_midframe_reset();
        logic early;
        logic [7:0] data;
        int nvalid;
        int w0;
        w0 = wen_count;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
        rstn = 1'b0;
        #2;
        tests_run++; if ({sready, svalid, srdata, mem_wen, mem_ren, timeout_err} !== 6'b100000) begin tests_failed++; $display("[TB] FAIL rst_outputs: got %b want 100000", {sready, svalid, srdata, mem_wen, mem_ren, timeout_err}); end
        tests_run++; if ({mem_addr, mem_wdata} !== 20'h0) begin tests_failed++; $display("[TB] FAIL rst_buses: got %h want 00000", {mem_addr, mem_wdata}); end
        step();
        rstn = 1'b1;
        repeat (20) step();
        tests_run++; if (wen_count - w0 !== 0) begin tests_failed++; $display("[TB] FAIL rst_no_wen: got %0d want 0", wen_count - w0); end
        send_frame(1'b0, 12'h001, 8'h00);
        tests_run++; if ({mem_ren, mem_addr} !== {1'b1, 12'h001}) begin tests_failed++; $display("[TB] FAIL rst_read_req: got ren,addr=%b,%h want 1,001", mem_ren, mem_addr); end
        collect_read(early, data, nvalid);
        tests_run++; if ({data, nvalid[3:0]} !== {8'hA6, 4'd8}) begin tests_failed++; $display("[TB] FAIL rst_read_data: got data=%h valid=%0d want a6 8", data, nvalid); end
    endtask

    task automatic test_stall();
        logic early;
        logic [7:0] data;
        int nvalid;
        int w0;
        int r0;
        logic seen_err;
        w0 = wen_count;
        r0 = ren_count;
        seen_err = 1'b0;
`ifdef SLAVE_PORT_TIMEOUT_EN
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step();
            if (timeout_err !== 1'b0 || sready !== 1'b0) seen_err = 1'b1;
        end
        tests_run++; if (seen_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_early: got early abort=%b want 0", seen_err); end
        step();
        tests_run++; if ({timeout_err, sready} !== 2'b11) begin tests_failed++; $display("[TB] FAIL to_abort: got err,sready=%b want 11", {timeout_err, sready}); end
        step();
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_pulse: got %b want 0", timeout_err); end
        tests_run++; if ((wen_count - w0) + (ren_count - r0) !== 0) begin tests_failed++; $display("[TB] FAIL to_no_strobe: got %0d want 0", (wen_count - w0) + (ren_count - r0)); end
        send_frame(1'b0, 12'h0A5, 8'h00);
`else
        for (int i = 0; i < 4; i++) send_bit(((12'h0A5 >> i) & 12'h1) != 0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step();
            if (timeout_err !== 1'b0 || sready !== 1'b0) seen_err = 1'b1;
        end
        tests_run++; if (seen_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_hold: got err_or_ready=%b want 0", seen_err); end
        for (int i = 4; i < 12; i++) send_bit(((12'h0A5 >> i) & 12'h1) != 0, 1'b0);
`endif
        tests_run++; if ({mem_ren, mem_addr} !== {1'b1, 12'h0A5}) begin tests_failed++; $display("[TB] FAIL stall_read_req: got ren,addr=%b,%h want 1,0a5", mem_ren, mem_addr); end
        collect_read(early, data, nvalid);
        tests_run++; if (data !== 8'h3C) begin tests_failed++; $display("[TB] FAIL stall_read_data: got %h want 3c", data); end
    endtask

    task automatic test_back_to_back();
        logic early;
        logic [7:0] data;
        int nvalid;
        int c0;
        send_frame(1'b1, 12'h010, 8'h55);
        c0 = cycle_cnt;
        step();
        tests_run++; if (sready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %b want 1", sready); end
        send_frame(1'b0, 12'h010, 8'h00);
        tests_run++; if (cycle_cnt - c0 !== 13) begin tests_failed++; $display("[TB] FAIL b2b_latency: got %0d edges want 13", cycle_cnt - c0); end
        tests_run++; if ({mem_ren, mem_addr} !== {1'b1, 12'h010}) begin tests_failed++; $display("[TB] FAIL b2b_read_req: got ren,addr=%b,%h want 1,010", mem_ren, mem_addr); end
        collect_read(early, data, nvalid);
        tests_run++; if ({early, data, nvalid[3:0]} !== {1'b0, 8'h55, 4'd8}) begin tests_failed++; $display("[TB] FAIL b2b_read_data: got early=%b data=%h valid=%0d want 0 55 8", early, data, nvalid); end
        tests_run++; if (sready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_end_ready: got %b want 1", sready); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[1] = 8'hA6;
        test_reset();
        test_write();
        test_read();
        test_gap_write();
        test_midframe_reset();
        test_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
